// File: rtl/vga_pic_gen.sv
// vga_pic_gen: bouncing ROM-image pixel source for the VGA display stage.
// Define VGA_PIC_COLORKEY_EN to show KEY_COLOR image pixels as background.
module vga_pic_gen #(
  parameter int          H_ACT     = 640,
  parameter int          V_ACT     = 480,
  parameter int          IMG_W     = 100,
  parameter int          IMG_H     = 100,
  parameter int          ROM_AW    = 14,
  parameter int          STEP      = 1,
  parameter logic [20:0] BG_COLOR  = 21'h000000,
  parameter logic [20:0] KEY_COLOR = 21'h1FC07F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       addr_h,
  input  logic [11:0]       addr_v,
  input  logic              pause,
  input  logic [20:0]       rom_q,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [20:0]       rgb_data,
  output logic              frame_tick
);

`ifdef VGA_PIC_COLORKEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    WAIT_START,
    SCAN,
    UPDATE
  } state_t;

  state_t      state;
  logic [11:0] pos_x;
  logic [11:0] pos_y;
  logic        dir_x;
  logic        dir_y;
  logic        sel1;
  logic        sel2;

  logic [12:0] x_end;
  logic [12:0] y_end;
  logic        in_img;
  logic [11:0] off_x;
  logic [11:0] off_y;
  logic        first_px;
  logic        last_px;
  logic        key_hit;

  logic [12:0] nxt_x;
  logic [12:0] nxt_y;

  // {new_dir, new_pos}; dir 1 = increasing
  function automatic logic [12:0] step_axis(
    input logic [11:0] p,
    input logic        d,
    input int          len,
    input int          lim
  );
    logic [12:0] r;
    if (d) begin
      if ({1'b0, p} + 13'(len - 1 + STEP) > 13'(lim))
        r = {1'b0, p - 12'(STEP)};
      else
        r = {1'b1, p + 12'(STEP)};
    end else begin
      if (p <= 12'(STEP))
        r = {1'b1, p + 12'(STEP)};
      else
        r = {1'b0, p - 12'(STEP)};
    end
    return r;
  endfunction

  assign x_end = {1'b0, pos_x} + 13'(IMG_W - 1);
  assign y_end = {1'b0, pos_y} + 13'(IMG_H - 1);

  assign in_img = (addr_h != 12'd0) && (addr_v != 12'd0) &&
                  (addr_h >= pos_x) && ({1'b0, addr_h} <= x_end) &&
                  (addr_v >= pos_y) && ({1'b0, addr_v} <= y_end);

  assign off_x = addr_h - pos_x;
  assign off_y = addr_v - pos_y;

  assign first_px = (addr_h == 12'd1) && (addr_v == 12'd1);
  assign last_px  = (addr_h == 12'(H_ACT)) && (addr_v == 12'(V_ACT));

  assign key_hit = KEY_EN && (rom_q == KEY_COLOR);

  assign nxt_x = step_axis(pos_x, dir_x, IMG_W, H_ACT);
  assign nxt_y = step_axis(pos_y, dir_y, IMG_H, V_ACT);

  // Two-stage pixel path; the external ROM forms the middle stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr <= '0;
      sel1     <= 1'b0;
      sel2     <= 1'b0;
      rgb_data <= '0;
    end else begin
      if (in_img)
        rom_addr <= ROM_AW'(24'(off_y) * 24'(IMG_W) + 24'(off_x));
      sel1     <= in_img;
      sel2     <= sel1;
      rgb_data <= (sel2 && !key_hit) ? rom_q : BG_COLOR;
    end
  end

  // Window moves only in the single UPDATE cycle after the last pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WAIT_START;
      frame_tick <= 1'b0;
      pos_x      <= 12'd1;
      pos_y      <= 12'd1;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
    end else begin
      unique case (state)
        WAIT_START: begin
          frame_tick <= 1'b0;
          if (first_px)
            state <= SCAN;
        end
        SCAN: begin
          if (last_px) begin
            state      <= UPDATE;
            frame_tick <= 1'b1;
          end
        end
        UPDATE: begin
          state      <= WAIT_START;
          frame_tick <= 1'b0;
          if (!pause) begin
            dir_x <= nxt_x[12];
            pos_x <= nxt_x[11:0];
            dir_y <= nxt_y[12];
            pos_y <= nxt_y[11:0];
          end
        end
        default: begin
          state      <= WAIT_START;
          frame_tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pic_gen.sv
// tb_vga_pic_gen: randomized pixel stimulus against a behavioural
// window/bounce model, compared on every cycle.
module tb_vga_pic_gen;

  localparam int          H_ACT  = 640;
  localparam int          V_ACT  = 480;
  localparam int          IMG_W  = 100;
  localparam int          IMG_H  = 100;
  localparam int          ROM_AW = 14;
  localparam int          STEP   = 1;
  localparam logic [20:0] BG     = 21'h000000;
  localparam logic [20:0] KEY    = 21'h1FC07F;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [11:0]       addr_h = '0;
  logic [11:0]       addr_v = '0;
  logic              pause = 1'b0;
  logic [20:0]       rom_q;
  logic [ROM_AW-1:0] rom_addr;
  logic [20:0]       rgb_data;
  logic              frame_tick;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  always #20 clk = ~clk;

  vga_pic_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_h     (addr_h),
    .addr_v     (addr_v),
    .pause      (pause),
    .rom_q      (rom_q),
    .rom_addr   (rom_addr),
    .rgb_data   (rgb_data),
    .frame_tick (frame_tick)
  );

  // Image content: the address itself, except one keyed pixel
  function automatic logic [20:0] rom_data(input int a);
    return (a == 5) ? KEY : 21'(a);
  endfunction

  always @(posedge clk) rom_q <= rom_data(int'(rom_addr));

  // Behavioural model
  int          mx, my, mdx, mdy, m_addr;
  bit          armed, m_tick, m_ok;
  logic [20:0] m_rgb, p1, p2;

  always @(posedge clk) begin : mdl
    int          ah, av;
    bit          hit;
    logic [20:0] d;
    if (!rst_n) begin
      mx = 1; my = 1; mdx = 1; mdy = 1;
      armed = 0; m_tick = 0; m_addr = 0;
      m_rgb = 21'h0; p1 = BG; p2 = BG; m_ok = 1;
    end else begin
      ah = int'(addr_h);
      av = int'(addr_v);
      hit = ah > 0 && av > 0 && ah >= mx && ah < mx + IMG_W &&
            av >= my && av < my + IMG_H;
      m_rgb = p2;
      p2 = p1;
      if (hit) begin
        m_addr = ((av - my) * IMG_W + (ah - mx)) % (1 << ROM_AW);
        d = rom_data(m_addr);
`ifdef VGA_PIC_COLORKEY_EN
        p1 = (d == KEY) ? BG : d;
`else
        p1 = d;
`endif
      end else begin
        p1 = BG;
      end
      if (m_tick) begin
        m_tick = 0;
        if (!pause) begin
          if (mdx > 0) begin
            if (mx + IMG_W - 1 + STEP > H_ACT) begin mdx = -1; mx -= STEP; end
            else mx += STEP;
          end else begin
            if (mx <= STEP) begin mdx = 1; mx += STEP; end
            else mx -= STEP;
          end
          if (mdy > 0) begin
            if (my + IMG_H - 1 + STEP > V_ACT) begin mdy = -1; my -= STEP; end
            else my += STEP;
          end else begin
            if (my <= STEP) begin mdy = 1; my += STEP; end
            else my -= STEP;
          end
        end
      end else if (!armed && ah == 1 && av == 1) begin
        armed = 1;
      end else if (armed && ah == H_ACT && av == V_ACT) begin
        armed = 0;
        m_tick = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("rgb_data", 32'(rgb_data), 32'(m_rgb));
      chk("frame_tick", 32'(frame_tick), 32'(m_tick));
      chk("rom_addr", 32'(rom_addr), 32'(m_addr));
      if (frame_tick === 1'b1) ticks++;
    end
  end

  task automatic px(input int h, input int v);
    @(negedge clk);
    addr_h = 12'(h);
    addr_v = 12'(v);
  endtask

  task automatic rand_px();
    int h, v;
    if ($urandom_range(1, 0) == 1) begin
      h = mx - 2 + int'($urandom_range(IMG_W + 3, 0));
      v = my - 2 + int'($urandom_range(IMG_H + 3, 0));
    end else begin
      h = int'($urandom_range(H_ACT, 0));
      v = int'($urandom_range(V_ACT, 0));
    end
    if (h < 0) h = 0;
    if (h > H_ACT) h = H_ACT;
    if (v < 0) v = 0;
    if (v > V_ACT) v = V_ACT;
    if (h == H_ACT && v == V_ACT) v = V_ACT - 1;
    px(h, v);
  endtask

  task automatic frame(input int n, input bit pz);
    pause = pz;
    px(1, 1);
    repeat (n) rand_px();
    px(H_ACT, V_ACT);
    repeat (3) px(0, 0);
  endtask

  initial begin : stim
    int sx, sy, t0, ybc;
    bit ypend;

    // Reset state
    repeat (2) px(0, 0);
    chk("rst_rgb", 32'(rgb_data), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_addr", 32'(rom_addr), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Address mapping at the reset position
    ticks = 0;
    pause = 1'b0;
    px(1, 1);
    px(20, 30);
    px(0, 0);
    chk("map_addr", 32'(rom_addr), 32'd2919);
    repeat (2) px(0, 0);
    chk("map_rgb", 32'(rgb_data), 32'd2919);
    px(150, 30);
    px(0, 0);
    chk("out_addr_hold", 32'(rom_addr), 32'd2919);
    repeat (2) px(0, 0);
    chk("out_rgb_bg", 32'(rgb_data), 32'(BG));
    px(6, 1);
    px(0, 0);
    chk("key_addr", 32'(rom_addr), 32'd5);
    repeat (2) px(0, 0);
`ifdef VGA_PIC_COLORKEY_EN
    chk("key_rgb", 32'(rgb_data), 32'(BG));
`else
    chk("key_rgb", 32'(rgb_data), 32'(KEY));
`endif
    px(H_ACT, V_ACT);
    repeat (3) px(0, 0);

    // Three frames in total
    frame(6, 1'b0);
    frame(6, 1'b0);
    chk("tick_count3", 32'(ticks), 32'd3);
    chk("pin_pos_x4", 32'(mx), 32'd4);
    chk("pin_pos_y4", 32'(my), 32'd4);
    px(5, 5);
    px(4, 4);
    chk("addr_5_5", 32'(rom_addr), 32'd101);
    px(0, 0);
    chk("addr_4_4", 32'(rom_addr), 32'd0);

    // Pause holds the window, tick still fires
    sx = mx; sy = my; t0 = ticks;
    frame(4, 1'b1);
    chk("pause_tick", 32'(ticks - t0), 32'd1);
    chk("pause_pin_x", 32'(mx), 32'(sx));
    chk("pause_pin_y", 32'(my), 32'(sy));
    px(sx + 1, sy + 1);
    px(sx, sy);
    px(0, 0);
    chk("pause_dut_pos", 32'(rom_addr), 32'd0);
    frame(4, 1'b0);
    chk("resume_pin_x", 32'(mx), 32'(sx + 1));

    // Run until the right-edge bounce; pin the bottom bounce on the way
    ybc = 0;
    for (int i = 0; i < 700; i++) begin
      if (mx == 541 && mdx > 0) break;
      ypend = (my == 381 && mdy > 0);
      frame(2, 1'b0);
      if (ypend) begin
        chk("ybounce_pos", 32'(my), 32'd380);
        chk("ybounce_dir", 32'(mdy), 32'(-1));
        ybc++;
      end
    end
    chk("ybounce_seen", 32'(ybc), 32'd1);
    chk("reach_541", 32'(mx), 32'd541);
    frame(2, 1'b0);
    chk("xbounce_pos", 32'(mx), 32'd540);
    chk("xbounce_dir", 32'(mdx), 32'(-1));
    px(540, my);
    px(541, my);
    px(0, 0);
    chk("xbounce_dut", 32'(rom_addr), 32'd1);

    // Reset mid-scan
    t0 = ticks;
    px(1, 1);
    repeat (3) rand_px();
    @(negedge clk);
    rst_n = 1'b0;
    addr_h = '0;
    addr_v = '0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_rgb", 32'(rgb_data), 32'h0);
    chk("mid_rst_tick", 32'(frame_tick), 32'h0);
    chk("mid_rst_addr", 32'(rom_addr), 32'h0);
    px(2, 2);
    px(0, 0);
    chk("mid_rst_pos", 32'(rom_addr), 32'd101);
    px(H_ACT, V_ACT);
    px(0, 0);
    chk("partial_no_tick", 32'(frame_tick), 32'h0);
    repeat (2) px(0, 0);
    chk("partial_no_count", 32'(ticks - t0), 32'd0);
    frame(5, 1'b0);
    chk("resync_tick", 32'(ticks - t0), 32'd1);

    // Random frames with random pause
    for (int i = 0; i < 40; i++)
      frame(int'($urandom_range(12, 2)), 1'($urandom_range(3, 0) == 0));

    repeat (3) px(0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
